// File: rtl/line_word_burst_sel_if.sv
// line_word_burst_sel_if: request and beat-stream signals for the cache-line word selector.
interface line_word_burst_sel_if #(
    parameter int WIDTH = 16,
    parameter int WORDS = 32
);
    localparam int SELW = $clog2(WORDS);
    logic [WIDTH*WORDS-1:0] line_in;
    logic                   req_valid;
    logic                   req_ready;
    logic [SELW-1:0]        req_sel;
    logic [SELW-1:0]        req_len_m1;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_index;
    logic                   out_last;
    modport master (
        output line_in, req_valid, req_sel, req_len_m1, out_ready,
        input  req_ready, out_valid, out_data, out_index, out_last
    );
    modport slave (
        input  line_in, req_valid, req_sel, req_len_m1, out_ready,
        output req_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/line_word_burst_sel.sv
// line_word_burst_sel: snapshots a cache line and streams a wrapping critical-word-first burst.
module line_word_burst_sel #(
    parameter int WIDTH = 16,
    parameter int WORDS = 32
) (
    input logic clk,
    input logic rst,
    line_word_burst_sel_if.slave bus
);
    localparam int SELW = $clog2(WORDS);
    typedef enum logic {IDLE, BURST} state_t;
    state_t                 state;
    logic [WIDTH*WORDS-1:0] snap;
    logic [SELW-1:0]        idx;
    logic [SELW-1:0]        rem;
    logic                   accept;
    logic                   beat;
    // Outputs come straight from flops, so async reset clears them without a clock.
    assign bus.out_valid = state == BURST;
    assign bus.out_last  = (state == BURST) && (rem == '0);
    assign bus.out_index = idx;
    assign bus.out_data  = snap[idx*WIDTH +: WIDTH];
    assign beat          = bus.out_valid && bus.out_ready;
    assign bus.req_ready = (state == IDLE) || (beat && bus.out_last);
    assign accept        = bus.req_valid && bus.req_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            snap  <= '0;
            idx   <= '0;
            rem   <= '0;
        end else if (accept) begin
            state <= BURST;
            snap  <= bus.line_in;
            idx   <= bus.req_sel;
            rem   <= bus.req_len_m1;
        end else if (beat) begin
            if (rem != '0) begin
                idx <= idx + 1'b1;
                rem <= rem - 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
